n_power_counter_fwd_diff: RTL and testbench

//   Parametrised up-counter that outputs n, n^2 and n^3 every cycle without multipliers.

---
 rtl/n_power_counter_fwd_diff_pkg.sv | 23 ++
 rtl/n_power_counter_fwd_diff_step.sv | 37 +++
 rtl/n_power_counter_fwd_diff.sv | 131 +++++++++++++
 tb/tb_n_power_counter_fwd_diff.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/n_power_counter_fwd_diff_pkg.sv
// Shared definitions for the forward-difference power counter: state encoding,
// difference-step constants and derived widths.
package n_power_counter_fwd_diff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEEK = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  localparam int DS_STEP = 2;
  localparam int DC_STEP = 6;

  function automatic int sq_w(input int w);
    return 2 * w;
  endfunction

  function automatic int cu_w(input int w);
    return 3 * w;
  endfunction

endpackage

// File: rtl/n_power_counter_fwd_diff_step.sv
// Combinational forward-difference step: advances n, n^2, n^3 and their
// difference registers by one using adders only.
module fwd_diff_step
  import n_power_counter_fwd_diff_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0]         n,
  input  logic [sq_w(W)-1:0]   sq,
  input  logic [cu_w(W)-1:0]   cube,
  input  logic [2*W:0]         ds,
  input  logic [3*W+1:0]       dc1,
  input  logic [W+2:0]         dc2,
  output logic [W-1:0]         n_nxt,
  output logic [sq_w(W)-1:0]   sq_nxt,
  output logic [cu_w(W)-1:0]   cube_nxt,
  output logic [2*W:0]         ds_nxt,
  output logic [3*W+1:0]       dc1_nxt,
  output logic [W+2:0]         dc2_nxt
);

  logic [2*W:0]   sq_sum;
  logic [3*W+1:0] cu_sum;

  // Sums are formed at the difference-register width; n never passes the
  // limit, so the truncated upper bits are always zero.
  assign sq_sum   = {1'b0, sq} + ds;
  assign cu_sum   = {2'b00, cube} + dc1;

  assign n_nxt    = n + W'(1);
  assign sq_nxt   = sq_sum[sq_w(W)-1:0];
  assign cube_nxt = cu_sum[cu_w(W)-1:0];
  assign ds_nxt   = ds + (2*W+1)'(DS_STEP);
  assign dc1_nxt  = dc1 + {{(2*W-1){1'b0}}, dc2};
  assign dc2_nxt  = dc2 + (W+3)'(DC_STEP);

endmodule

// File: rtl/n_power_counter_fwd_diff.sv
// Multiplier-free counter producing n, n^2, n^3 with seek-to-start, limit,
// enable and halt/wrap end-of-sequence behaviour.
module n_power_counter_fwd_diff
  import n_power_counter_fwd_diff_pkg::*;
#(
  parameter int COUNT_WIDTH = 4,
  parameter bit WRAP_MODE   = 1'b0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [COUNT_WIDTH-1:0]         start_val,
  input  logic [COUNT_WIDTH-1:0]         limit,
  input  logic                           en,
  output logic [COUNT_WIDTH-1:0]         count,
  output logic [sq_w(COUNT_WIDTH)-1:0]   count_squared,
  output logic [cu_w(COUNT_WIDTH)-1:0]   count_cubed,
  output logic                           valid,
  output logic                           busy,
  output logic                           done,
  output logic                           wrapped
);

  localparam int W = COUNT_WIDTH;

  state_t              state;
  logic [W-1:0]        tgt_q, lim_q, tgt;
  logic [2*W:0]        ds;
  logic [3*W+1:0]      dc1;
  logic [W+2:0]        dc2;

  logic [W-1:0]        n_nxt;
  logic [sq_w(W)-1:0]  sq_nxt;
  logic [cu_w(W)-1:0]  cube_nxt;
  logic [2*W:0]        ds_nxt;
  logic [3*W+1:0]      dc1_nxt;
  logic [W+2:0]        dc2_nxt;

  assign tgt = (start_val < limit) ? start_val : limit;

  fwd_diff_step #(.W(W)) u_step (
    .n        (count),
    .sq       (count_squared),
    .cube     (count_cubed),
    .ds       (ds),
    .dc1      (dc1),
    .dc2      (dc2),
    .n_nxt    (n_nxt),
    .sq_nxt   (sq_nxt),
    .cube_nxt (cube_nxt),
    .ds_nxt   (ds_nxt),
    .dc1_nxt  (dc1_nxt),
    .dc2_nxt  (dc2_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      tgt_q         <= '0;
      lim_q         <= '0;
      count         <= '0;
      count_squared <= '0;
      count_cubed   <= '0;
      ds            <= '0;
      dc1           <= '0;
      dc2           <= '0;
      valid         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      wrapped       <= 1'b0;
    end else begin
      done    <= 1'b0;
      wrapped <= 1'b0;
      if (start) begin
        state         <= ST_SEEK;
        tgt_q         <= tgt;
        lim_q         <= limit;
        count         <= '0;
        count_squared <= '0;
        count_cubed   <= '0;
        ds            <= (2*W+1)'(1);
        dc1           <= (3*W+2)'(1);
        dc2           <= (W+3)'(DC_STEP);
        valid         <= 1'b0;
        busy          <= 1'b1;
      end else begin
        case (state)
          ST_SEEK: begin
            if (count == tgt_q) begin
              state <= ST_RUN;
              busy  <= 1'b0;
              valid <= 1'b1;
            end else begin
              count         <= n_nxt;
              count_squared <= sq_nxt;
              count_cubed   <= cube_nxt;
              ds            <= ds_nxt;
              dc1           <= dc1_nxt;
              dc2           <= dc2_nxt;
            end
          end
          ST_RUN: begin
            if (en) begin
              if (count != lim_q) begin
                count         <= n_nxt;
                count_squared <= sq_nxt;
                count_cubed   <= cube_nxt;
                ds            <= ds_nxt;
                dc1           <= dc1_nxt;
                dc2           <= dc2_nxt;
              end else if (WRAP_MODE) begin
                count         <= '0;
                count_squared <= '0;
                count_cubed   <= '0;
                ds            <= (2*W+1)'(1);
                dc1           <= (3*W+2)'(1);
                dc2           <= (W+3)'(DC_STEP);
                wrapped       <= 1'b1;
              end else begin
                state <= ST_HALT;
                done  <= 1'b1;
              end
            end
          end
          default: ;  // IDLE and HALT hold until start or reset
        endcase
      end
    end
  end

endmodule

// File: tb/tb_n_power_counter_fwd_diff.sv
// Directed bench for the power counter: one halt-mode and one wrap-mode
// instance share stimulus; expectations are hand-derived constants.
module tb_n_power_counter_fwd_diff;

  logic        clk = 1'b0;
  logic        reset, start, en;
  logic [3:0]  start_val, limit;

  logic [3:0]  count0, count1;
  logic [7:0]  sq0, sq1;
  logic [11:0] cu0, cu1;
  logic        valid0, busy0, done0, wrapped0;
  logic        valid1, busy1, done1, wrapped1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  n_power_counter_fwd_diff #(.COUNT_WIDTH(4), .WRAP_MODE(1'b0)) dut_halt (
    .clk(clk), .reset(reset), .start(start), .start_val(start_val),
    .limit(limit), .en(en), .count(count0), .count_squared(sq0),
    .count_cubed(cu0), .valid(valid0), .busy(busy0), .done(done0),
    .wrapped(wrapped0)
  );

  n_power_counter_fwd_diff #(.COUNT_WIDTH(4), .WRAP_MODE(1'b1)) dut_wrap (
    .clk(clk), .reset(reset), .start(start), .start_val(start_val),
    .limit(limit), .en(en), .count(count1), .count_squared(sq1),
    .count_cubed(cu1), .valid(valid1), .busy(busy1), .done(done1),
    .wrapped(wrapped1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [3:0] sv, input logic [3:0] lim);
    start_val = sv;
    limit     = lim;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic chk_pt(input string tag, input int n);
    chk({tag, "_n"},    32'(count0), 32'(n));
    chk({tag, "_sq"},   32'(sq0),    32'(n * n));
    chk({tag, "_cube"}, 32'(cu0),    32'(n * n * n));
  endtask

  initial begin
    int b;
    int exp_cube [8] = '{1, 8, 27, 0, 1, 8, 27, 0};

    reset = 1'b1; start = 1'b0; en = 1'b0; start_val = '0; limit = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_count", 32'(count0), 0);
    chk("rst_cube",  32'(cu0),    0);
    chk("rst_valid", 32'(valid0), 0);
    chk("rst_busy",  32'(busy0),  0);
    en = 1'b1;
    tick(); tick();
    chk("idle_valid", 32'(valid0), 0);
    chk("idle_count", 32'(count0), 0);

    // full sweep 0..15 then halt
    pulse_start(4'd0, 4'd15);
    chk("t1_busy",  32'(busy0),  1);
    chk("t1_valid0", 32'(valid0), 0);
    tick();
    chk("t1_valid", 32'(valid0), 1);
    chk_pt("t1_first", 0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk_pt("t1_run", i);
      chk("t1_nodone", 32'(done0), 0);
    end
    tick();
    chk("t1_done", 32'(done0), 1);
    chk_pt("t1_halt", 15);
    tick();
    chk("t1_done_low", 32'(done0), 0);
    chk("t1_halt_valid", 32'(valid0), 1);
    chk_pt("t1_hold", 15);

    // seek to 5, then freeze at 7
    pulse_start(4'd5, 4'd15);
    b = 0;
    while (busy0 && b < 20) begin b++; tick(); end
    chk("t2_busy_cycles", 32'(b), 6);
    chk("t2_valid", 32'(valid0), 1);
    chk_pt("t2_first", 5);
    tick(); tick();
    chk_pt("t3_at7", 7);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_pt("t3_frozen", 7);
    end
    en = 1'b1;
    tick();
    chk_pt("t3_resume", 8);

    // start above limit clamps the target
    en = 1'b0;
    pulse_start(4'd12, 4'd9);
    b = 0;
    while (!valid0 && b < 30) begin b++; tick(); end
    chk("t5_valid", 32'(valid0), 1);
    chk_pt("t5_seek", 9);
    en = 1'b1;
    tick();
    chk("t5_done", 32'(done0), 1);
    chk_pt("t5_halt", 9);
    en = 1'b0;

    // restart mid-seek
    pulse_start(4'd10, 4'd15);
    tick(); tick(); tick();
    chk("t6_mid_n", 32'(count0), 3);
    pulse_start(4'd2, 4'd15);
    chk("t6_restart_n", 32'(count0), 0);
    chk("t6_restart_busy", 32'(busy0), 1);
    b = 0;
    while (!valid0 && b < 20) begin b++; tick(); end
    chk("t6_cycles", 32'(b), 3);
    chk_pt("t6_first", 2);

    // asynchronous reset mid-run
    en = 1'b1;
    tick(); tick();
    chk_pt("t7_run", 4);
    #2 reset = 1'b1;
    #1;
    chk("t7_async_n",     32'(count0), 0);
    chk("t7_async_cube",  32'(cu0),    0);
    chk("t7_async_valid", 32'(valid0), 0);
    #1 reset = 1'b0;
    tick(); tick();
    chk("t7_idle_valid", 32'(valid0), 0);
    chk("t7_idle_n",     32'(count0), 0);

    // wrap mode, limit 3
    pulse_start(4'd0, 4'd3);
    tick();
    chk("t4_valid", 32'(valid1), 1);
    chk("t4_cube0", 32'(cu1), 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t4_cube", 32'(cu1), 32'(exp_cube[i]));
      chk("t4_wrapped", 32'(wrapped1), (exp_cube[i] == 0) ? 1 : 0);
    end
    chk("t4_no_done", 32'(done1), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
